// File: rtl/spm_mem_responder.sv
// Fixed-latency, in-order cache-line read responder backed by a preloadable line array.
// Requests queue with a per-entry countdown; the head retires into registered response outputs.
module spm_mem_responder #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned LAT    = 4,
    parameter int unsigned OUTST  = 8,
    parameter int unsigned LINE_W = 512
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_req_val,
    output logic                      mem_req_rdy,
    input  logic [5:0]                mem_req_transid,
    input  logic [39:0]               mem_req_addr,
    output logic                      mem_resp_val,
    output logic [5:0]                mem_resp_transid,
    output logic [LINE_W-1:0]         mem_resp_data,
    input  logic                      req_stall,
    input  logic                      pl_we,
    input  logic [$clog2(DEPTH)-1:0]  pl_idx,
    input  logic [LINE_W-1:0]         pl_data,
    output logic [$clog2(OUTST):0]    outstanding,
    output logic                      addr_err
);
    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(OUTST) + 1;
    localparam int unsigned PtrW = (OUTST > 1) ? $clog2(OUTST) : 1;
    localparam int unsigned CdW  = 4;

    logic [LINE_W-1:0] mem_q [DEPTH];

    logic [OUTST-1:0] ent_vld_q, ent_vld_d;
    logic [OUTST-1:0] ent_err_q, ent_err_d;
    logic [5:0]       ent_tid_q [OUTST];
    logic [5:0]       ent_tid_d [OUTST];
    logic [IdxW-1:0]  ent_idx_q [OUTST];
    logic [IdxW-1:0]  ent_idx_d [OUTST];
    logic [CdW-1:0]   ent_cd_q  [OUTST];
    logic [CdW-1:0]   ent_cd_d  [OUTST];

    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              resp_val_q, resp_val_d;
    logic [5:0]        resp_tid_q, resp_tid_d;
    logic [LINE_W-1:0] resp_data_q, resp_data_d;
    logic              addr_err_q, addr_err_d;

    logic accept, pop, req_err;
    logic unused_addr_lo;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    // Line offset bits never select anything; requests are line-aligned.
    assign unused_addr_lo = ^mem_req_addr[5:0];

    assign req_err     = mem_req_addr[39:6] >= 34'(DEPTH);
    assign mem_req_rdy = !req_stall && (count_q < CntW'(OUTST));
    assign accept      = mem_req_val && mem_req_rdy;
    assign pop         = ent_vld_q[rd_ptr_q] && (ent_cd_q[rd_ptr_q] == '0);

    always_comb begin
        ent_vld_d   = ent_vld_q;
        ent_err_d   = ent_err_q;
        ent_tid_d   = ent_tid_q;
        ent_idx_d   = ent_idx_q;
        ent_cd_d    = ent_cd_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        resp_val_d  = 1'b0;
        resp_tid_d  = resp_tid_q;
        resp_data_d = resp_data_q;
        addr_err_d  = addr_err_q;

        for (int i = 0; i < OUTST; i++) begin
            if (ent_vld_q[i] && ent_cd_q[i] != '0) begin
                ent_cd_d[i] = ent_cd_q[i] - 1'b1;
            end
        end

        // Read happens against the pre-write array, so a same-edge preload is not visible.
        if (pop) begin
            ent_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d            = ptr_inc(rd_ptr_q);
            resp_val_d          = 1'b1;
            resp_tid_d          = ent_tid_q[rd_ptr_q];
            resp_data_d         = ent_err_q[rd_ptr_q] ? '0 : mem_q[ent_idx_q[rd_ptr_q]];
        end

        if (accept) begin
            ent_vld_d[wr_ptr_q] = 1'b1;
            ent_err_d[wr_ptr_q] = req_err;
            ent_tid_d[wr_ptr_q] = mem_req_transid;
            ent_idx_d[wr_ptr_q] = mem_req_addr[6 +: IdxW];
            ent_cd_d[wr_ptr_q]  = CdW'(LAT - 1);
            wr_ptr_d            = ptr_inc(wr_ptr_q);
            addr_err_d          = addr_err_q | req_err;
        end

        count_d = count_q + CntW'(accept) - CntW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_vld_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            resp_val_q  <= 1'b0;
            resp_tid_q  <= '0;
            resp_data_q <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            ent_vld_q   <= ent_vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            resp_val_q  <= resp_val_d;
            resp_tid_q  <= resp_tid_d;
            resp_data_q <= resp_data_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // Entry payload is qualified by ent_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        ent_err_q <= ent_err_d;
        ent_tid_q <= ent_tid_d;
        ent_idx_q <= ent_idx_d;
        ent_cd_q  <= ent_cd_d;
    end

    always_ff @(posedge clk) begin
        if (pl_we) begin
            mem_q[pl_idx] <= pl_data;
        end
    end

    assign mem_resp_val     = resp_val_q;
    assign mem_resp_transid = resp_tid_q;
    assign mem_resp_data    = resp_data_q;
    assign outstanding      = count_q;
    assign addr_err         = addr_err_q;

endmodule

// File: tb/tb_spm_mem_responder.sv
// Bench for spm_mem_responder: request-timing reference model feeding a response scoreboard,
// plus a second deep-latency instance for queue-full throttling.
module tb_spm_mem_responder;
    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LAT     = 4;
    localparam int unsigned OUTST   = 8;
    localparam int unsigned LINE_W  = 512;
    localparam int unsigned IDXW    = 10;
    localparam int unsigned F_DEPTH = 64;
    localparam int unsigned F_LAT   = 16;
    localparam int unsigned F_OUTST = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              mem_req_val, mem_req_rdy, req_stall, pl_we;
    logic [5:0]        mem_req_transid, mem_resp_transid;
    logic [39:0]       mem_req_addr;
    logic              mem_resp_val, addr_err;
    logic [LINE_W-1:0] mem_resp_data, pl_data;
    logic [IDXW-1:0]   pl_idx;
    logic [3:0]        outstanding;

    logic              f_val, f_rdy, f_resp_val, f_err;
    logic [5:0]        f_tid, f_resp_tid;
    logic [39:0]       f_addr;
    logic [LINE_W-1:0] f_resp_data;
    logic [3:0]        f_out;

    spm_mem_responder #(.DEPTH(DEPTH), .LAT(LAT), .OUTST(OUTST), .LINE_W(LINE_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
        .mem_req_transid(mem_req_transid), .mem_req_addr(mem_req_addr),
        .mem_resp_val(mem_resp_val), .mem_resp_transid(mem_resp_transid),
        .mem_resp_data(mem_resp_data), .req_stall(req_stall),
        .pl_we(pl_we), .pl_idx(pl_idx), .pl_data(pl_data),
        .outstanding(outstanding), .addr_err(addr_err)
    );

    spm_mem_responder #(.DEPTH(F_DEPTH), .LAT(F_LAT), .OUTST(F_OUTST), .LINE_W(LINE_W)) u_full (
        .clk(clk), .rst_n(rst_n),
        .mem_req_val(f_val), .mem_req_rdy(f_rdy),
        .mem_req_transid(f_tid), .mem_req_addr(f_addr),
        .mem_resp_val(f_resp_val), .mem_resp_transid(f_resp_tid),
        .mem_resp_data(f_resp_data), .req_stall(1'b0),
        .pl_we(1'b0), .pl_idx(6'd0), .pl_data('0),
        .outstanding(f_out), .addr_err(f_err)
    );

    typedef struct {
        logic [5:0]  tid;
        int unsigned line;
        bit          err;
        int unsigned due;
    } req_t;

    typedef struct {
        logic [5:0]        tid;
        logic [LINE_W-1:0] data;
    } rsp_t;

    req_t              pend[$];
    rsp_t              resp_q[$];
    logic [LINE_W-1:0] shadow [DEPTH];
    bit                m_err;
    bit                mon_en;
    int unsigned       cyc;
    int                checks;
    int                errors;

    task automatic chk(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [39:0] line_addr(input int unsigned line, input int unsigned off);
        return (40'(line) << 6) | 40'(off & 32'd63);
    endfunction

    // Reference model: each accept is due LAT edges later; data is the line as it stands
    // just before that edge's preload.
    initial begin
        req_t r;
        cyc = 0;
        m_err = 1'b0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (!rst_n) begin
                pend.delete();
                resp_q.delete();
                m_err = 1'b0;
            end else begin
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    r = pend.pop_front();
                    resp_q.push_back('{tid: r.tid, data: r.err ? '0 : shadow[r.line]});
                end
                if (mem_req_val && mem_req_rdy) begin
                    r.tid  = mem_req_transid;
                    r.err  = mem_req_addr[39:6] >= 34'(DEPTH);
                    r.line = r.err ? 0 : int'(mem_req_addr[6 +: IDXW]);
                    r.due  = cyc + LAT;
                    pend.push_back(r);
                    if (r.err) m_err = 1'b1;
                end
            end
            if (pl_we) shadow[pl_idx] = pl_data;
        end
    end

    // Monitor: every response must match the scoreboard head, in the exact expected cycle.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mem_resp_val) begin
                    if (resp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL resp_unexpected: got transid %0h, expected no response",
                                 mem_resp_transid);
                    end else begin
                        r = resp_q.pop_front();
                        chk("resp_transid", 512'(mem_resp_transid), 512'(r.tid));
                        chk("resp_data", mem_resp_data, r.data);
                    end
                end else if (resp_q.size() != 0) begin
                    r = resp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL resp_missing: got no response, expected transid %0h", r.tid);
                end
                chk("outstanding", 512'(outstanding), 512'(pend.size()));
                chk("req_rdy", 512'(mem_req_rdy), 512'(!req_stall && pend.size() < OUTST));
                chk("addr_err", 512'(addr_err), 512'(m_err));
            end
        end
    end

    task automatic pl_write(input int unsigned idx, input logic [LINE_W-1:0] d);
        pl_we   = 1'b1;
        pl_idx  = IDXW'(idx);
        pl_data = d;
        @(posedge clk);
        #1;
        pl_we = 1'b0;
    endtask

    task automatic send(input logic [5:0] tid, input logic [39:0] addr, output int waits);
        bit acc;
        waits           = 0;
        mem_req_val     = 1'b1;
        mem_req_transid = tid;
        mem_req_addr    = addr;
        while (1) begin
            @(negedge clk);
            acc = mem_req_rdy;
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
            if (waits > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no accept, expected one within 200 cycles");
                break;
            end
        end
        mem_req_val = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, tot, n, acc_cnt, rsp_cnt, first_rsp;
        int acc_edge [10];
        bit prev_acc;
        logic [LINE_W-1:0] old_d, new_d;

        checks = 0; errors = 0; mon_en = 1'b0;
        rst_n = 1'b0; mem_req_val = 1'b0; mem_req_transid = '0; mem_req_addr = '0;
        req_stall = 1'b0; pl_we = 1'b0; pl_idx = '0; pl_data = '0;
        f_val = 1'b0; f_tid = '0; f_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        @(negedge clk);
        chk("rst_resp_val", 512'(mem_resp_val), 512'(0));
        chk("rst_resp_transid", 512'(mem_resp_transid), 512'(0));
        chk("rst_resp_data", mem_resp_data, '0);
        chk("rst_outstanding", 512'(outstanding), 512'(0));
        chk("rst_addr_err", 512'(addr_err), 512'(0));
        @(posedge clk);
        #1;

        for (int i = 0; i < 32; i++) pl_write(i, rand_line());

        // Single request to line 3
        pl_write(3, {64{8'h0F}});
        send(6'h01, 40'hC4, w);
        chk("single_wait", 512'(w), 512'(0));
        repeat (LAT + 3) @(posedge clk);
        #1;

        // Streaming
        for (int i = 0; i < 12; i++) pl_write(i, LINE_W'(i));
        tot = 0;
        for (int i = 0; i < 12; i++) begin
            send(6'(i), line_addr(i, 0), w);
            tot += w;
        end
        chk("stream_rdy_drop", 512'(tot), 512'(0));
        repeat (LAT + 3) @(posedge clk);
        #1;

        // Stall with request held
        req_stall = 1'b1; mem_req_val = 1'b1; mem_req_transid = 6'h2A;
        mem_req_addr = line_addr(7, 21);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_req_rdy) n++;
            @(posedge clk);
            #1;
        end
        chk("stall_no_accept", 512'(n), 512'(0));
        req_stall = 1'b0;
        send(6'h2A, line_addr(7, 21), w);

        // Out-of-range line
        send(6'h33, 40'(DEPTH) << 6, w);
        repeat (LAT + 2) @(posedge clk);
        @(negedge clk);
        chk("addr_err_set", 512'(addr_err), 512'(1));
        @(posedge clk);
        #1;

        // Preload collides with the line-5 response edge
        old_d = rand_line();
        new_d = rand_line();
        pl_write(5, old_d);
        send(6'h05, line_addr(5, 0), w);
        repeat (LAT - 1) @(posedge clk);
        #1;
        pl_write(5, new_d);
        send(6'h06, line_addr(5, 0), w);
        repeat (LAT + 3) @(posedge clk);
        @(negedge clk);
        chk("addr_err_hold", 512'(addr_err), 512'(1));
        @(posedge clk);
        #1;

        // Randomized traffic
        repeat (400) begin
            mem_req_val     = ($urandom % 3) != 0;
            mem_req_transid = 6'($urandom);
            req_stall       = ($urandom % 10) == 0;
            if ($urandom % 16 == 0) mem_req_addr = line_addr(DEPTH + $urandom_range(0, 4000), $urandom);
            else mem_req_addr = line_addr($urandom_range(0, 31), $urandom);
            pl_we   = ($urandom % 4) == 0;
            pl_idx  = IDXW'($urandom_range(0, 31));
            pl_data = rand_line();
            @(posedge clk);
            #1;
        end
        mem_req_val = 1'b0; req_stall = 1'b0; pl_we = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;

        // Reset with requests in flight
        pl_write(40, {64{8'hA5}});
        for (int i = 0; i < 3; i++) send(6'(i + 8), line_addr(20 + i, 0), w);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_resp_val) n++;
        end
        chk("rst_flight_no_resp", 512'(n), 512'(0));
        chk("rst_flight_outstanding", 512'(outstanding), 512'(0));
        chk("rst_flight_addr_err", 512'(addr_err), 512'(0));
        @(posedge clk);
        #1;
        send(6'h3F, line_addr(40, 0), w);
        repeat (LAT + 3) @(posedge clk);
        #1;

        // Queue full on the LAT=16 instance; iteration k's negedge precedes edge k
        acc_cnt = 0; rsp_cnt = 0; first_rsp = -1; prev_acc = 1'b0;
        f_tid = 6'd0; f_addr = 40'd0; f_val = 1'b1;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (prev_acc) begin
                if (acc_cnt == 8) begin
                    chk("full_rdy_low", 512'(f_rdy), 512'(0));
                    chk("full_outstanding", 512'(f_out), 512'(F_OUTST));
                end
                f_tid  = 6'(acc_cnt);
                f_addr = 40'(acc_cnt) << 6;
                if (acc_cnt == 10) f_val = 1'b0;
            end
            if (f_resp_val) begin
                chk("full_resp_order", 512'(f_resp_tid), 512'(rsp_cnt));
                if (rsp_cnt == 0) first_rsp = k;
                rsp_cnt++;
            end
            prev_acc = f_val && f_rdy;
            if (prev_acc && acc_cnt < 10) begin
                acc_edge[acc_cnt] = k;
                acc_cnt++;
            end
        end
        f_val = 1'b0;
        chk("full_accepts", 512'(acc_cnt), 512'(10));
        chk("full_responses", 512'(rsp_cnt), 512'(10));
        chk("full_8th_accept", 512'(acc_edge[7] - acc_edge[0]), 512'(7));
        chk("full_9th_accept", 512'(acc_edge[8] - acc_edge[0]), 512'(F_LAT + 1));
        chk("full_10th_accept", 512'(acc_edge[9] - acc_edge[0]), 512'(F_LAT + 2));
        chk("full_first_resp", 512'(first_rsp - acc_edge[0]), 512'(F_LAT + 1));

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 512'(pend.size() + resp_q.size()), 512'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
